// File: rtl/mem_io_responder.sv
// Memory-side responder for the byte-serial RAM bus: byte RAM plus an I/O window holding
// a UART TX FIFO with 8N1 serializer, an RX holding register, a status and a halt register.
module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int FIFO_LOG2      = 3,
  parameter int BAUD_DIV       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        in_ram_rw,
  input  logic [31:0] in_ram_address,
  input  logic [7:0]  in_ram_data,
  output logic [7:0]  out_ram_data,
  output logic        out_uart_full,
  input  logic        in_rx_valid,
  input  logic [7:0]  in_rx_data,
  output logic        out_tx,
  output logic        out_overflow,
  output logic        out_halt
);

  localparam int DEPTH = 2 ** FIFO_LOG2;
  localparam logic [FIFO_LOG2:0]   CNT_FULL  = (FIFO_LOG2+1)'(DEPTH);
  localparam logic [FIFO_LOG2:0]   CNT_NEAR  = (FIFO_LOG2+1)'(DEPTH - 2);
  localparam logic [FIFO_LOG2:0]   CNT_ONE   = (FIFO_LOG2+1)'(1);
  localparam logic [FIFO_LOG2-1:0] PTR_ONE   = FIFO_LOG2'(1);
  localparam logic [15:0]          BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [31:0]          ADDR_UART = 32'h0003_0000;
  localparam logic [31:0]          ADDR_CTRL = 32'h0003_0004;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  logic [7:0]                mem [2**RAM_ADDR_WIDTH];
  logic [RAM_ADDR_WIDTH-1:0] ram_index;
  logic                      is_io;
  logic                      sel_uart;
  logic                      sel_ctrl;
  logic [7:0]                io_rdata;

  logic [7:0]                fifo [DEPTH];
  logic [FIFO_LOG2-1:0]      head;
  logic [FIFO_LOG2-1:0]      tail;
  logic [FIFO_LOG2:0]        count;
  logic [FIFO_LOG2:0]        count_next;
  logic                      fifo_full;
  logic                      push;
  logic                      push_ok;
  logic                      pop_tx;
  logic                      pop_rx;

  logic                      rx_valid;
  logic [7:0]                rx_buf;

  tx_state_t                 state;
  logic [15:0]               bcnt;
  logic [2:0]                bidx;
  logic [7:0]                shift;
  logic                      bit_end;

  assign is_io     = (in_ram_address[17:16] == 2'b11);
  assign ram_index = in_ram_address[RAM_ADDR_WIDTH-1:0];
  assign sel_uart  = (in_ram_address == ADDR_UART);
  assign sel_ctrl  = (in_ram_address == ADDR_CTRL);

  assign fifo_full = (count == CNT_FULL);
  assign push      = rdy && in_ram_rw && sel_uart;
  assign push_ok   = push && !fifo_full;
  assign pop_rx    = !in_ram_rw && sel_uart;
  // The serializer only sees a byte once count has registered it, so a fresh push is resident a cycle.
  assign pop_tx    = rdy && (state == IDLE) && (count != '0);
  assign bit_end   = (bcnt == BAUD_LAST);

  always_comb begin
    count_next = count;
    if (push_ok && !pop_tx)
      count_next = count + CNT_ONE;
    else if (!push_ok && pop_tx)
      count_next = count - CNT_ONE;
  end

  always_comb begin
    io_rdata = 8'h00;
    if (sel_uart)
      io_rdata = rx_valid ? rx_buf : 8'h00;
    else if (sel_ctrl)
      io_rdata = {6'b0, rx_valid, fifo_full};
  end

  // RAM and FIFO storage carry no reset.
  always_ff @(posedge clk) begin
    if (rdy && in_ram_rw && !is_io)
      mem[ram_index] <= in_ram_data;
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      fifo[tail] <= in_ram_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_ram_data  <= 8'h00;
      rx_valid      <= 1'b0;
      rx_buf        <= 8'h00;
      out_halt      <= 1'b0;
      out_overflow  <= 1'b0;
      out_uart_full <= 1'b0;
      count         <= '0;
      tail          <= '0;
    end else if (rdy) begin
      if (!in_ram_rw)
        out_ram_data <= is_io ? io_rdata : mem[ram_index];
      // A pulse arriving with a pop wins: the old byte is read out, the new one stays valid.
      if (in_rx_valid) begin
        rx_valid <= 1'b1;
        rx_buf   <= in_rx_data;
      end else if (pop_rx) begin
        rx_valid <= 1'b0;
      end
      if (in_ram_rw && sel_ctrl)
        out_halt <= 1'b1;
      if (push && fifo_full)
        out_overflow <= 1'b1;
      if (push_ok)
        tail <= tail + PTR_ONE;
      count         <= count_next;
      out_uart_full <= (count_next >= CNT_NEAR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      out_tx <= 1'b1;
      head   <= '0;
      bcnt   <= '0;
      bidx   <= '0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          out_tx <= 1'b1;
          if (count != '0) begin
            shift  <= fifo[head];
            head   <= head + PTR_ONE;
            bcnt   <= '0;
            out_tx <= 1'b0;
            state  <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bcnt   <= '0;
            bidx   <= '0;
            out_tx <= shift[0];
            state  <= DATA;
          end else begin
            bcnt <= bcnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            bcnt <= '0;
            if (bidx == 3'd7) begin
              out_tx <= 1'b1;
              state  <= STOP;
            end else begin
              bidx   <= bidx + 3'd1;
              shift  <= {1'b0, shift[7:1]};
              out_tx <= shift[1];
            end
          end else begin
            bcnt <= bcnt + 16'd1;
          end
        end
        default: begin
          if (bit_end) begin
            bcnt   <= '0;
            out_tx <= 1'b1;
            state  <= IDLE;
          end else begin
            bcnt <= bcnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed RAM / UART / RX / freeze / reset steps, then randomized
// traffic against a reference model; TX bytes are recovered by a line decoder.
module tb_mem_io_responder;

  localparam int BD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        in_ram_rw;
  logic [31:0] in_ram_address;
  logic [7:0]  in_ram_data;
  logic [7:0]  out_ram_data;
  logic        out_uart_full;
  logic        in_rx_valid;
  logic [7:0]  in_rx_data;
  logic        out_tx;
  logic        out_overflow;
  logic        out_halt;

  int          vectors = 0;
  int          errs = 0;
  int          frames = 0;
  logic [7:0]  expq[$];
  logic [7:0]  mem_model [256];
  logic [31:0] unmapped [4];

  mem_io_responder #(
    .RAM_ADDR_WIDTH(17),
    .FIFO_LOG2(3),
    .BAUD_DIV(BD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .in_ram_rw(in_ram_rw),
    .in_ram_address(in_ram_address),
    .in_ram_data(in_ram_data),
    .out_ram_data(out_ram_data),
    .out_uart_full(out_uart_full),
    .in_rx_valid(in_rx_valid),
    .in_rx_data(in_rx_data),
    .out_tx(out_tx),
    .out_overflow(out_overflow),
    .out_halt(out_halt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic rw, input logic [31:0] a, input logic [7:0] d);
    in_ram_rw      = rw;
    in_ram_address = a;
    in_ram_data    = d;
  endtask

  // Line level c cycles after the write cycle of an isolated byte: one idle cycle,
  // BD cycles of start, 8 data bits LSB first, then stop/idle high.
  function automatic logic exp_tx(input int c, input logic [7:0] b);
    if (c >= 2 && c <= BD + 1) return 1'b0;
    if (c >= BD + 2 && c <= 9 * BD + 1) return b[(c - BD - 2) / BD];
    return 1'b1;
  endfunction

  // Serial decoder: counts only cycles on which the DUT advances (rdy high).
  initial begin : uart_decoder
    logic [9:0] bits;
    logic [8:0] exp_b;
    int         n;
    bit         active;
    bit         glitch;
    bits = '0;
    n = 0;
    active = 0;
    glitch = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0;
      end else if (rdy) begin
        if (!active && out_tx === 1'b0) begin
          active = 1;
          n = 0;
          glitch = 0;
        end
        if (active) begin
          if (n % BD == 0) bits[n / BD] = out_tx;
          else if (out_tx !== bits[n / BD]) glitch = 1;
          n++;
          if (n == 10 * BD) begin
            active = 0;
            frames++;
            check("frame_shape", {29'b0, glitch, bits[9], bits[0]}, 32'h2);
            exp_b = 9'h100;
            if (expq.size() > 0) exp_b = {1'b0, expq.pop_front()};
            check("tx_byte", {23'b0, 1'b0, bits[8:1]}, {23'b0, exp_b});
          end
        end
      end
    end
  end

  initial begin
    logic [7:0]  b;
    logic [7:0]  b1;
    logic [7:0]  expd;
    logic [7:0]  wd;
    logic [7:0]  rxb;
    logic [7:0]  rxd;
    logic [31:0] ua;
    logic        rxv;
    logic        rxp;
    logic        rwv;
    logic        do_chk;
    logic        ovf_m;
    int          cnt_m;
    int          idle_cyc;
    int          fr0;
    int          op;
    int          idx;

    unmapped[0] = 32'h0003_0001;
    unmapped[1] = 32'h0003_0008;
    unmapped[2] = 32'hF003_0000;
    unmapped[3] = 32'h0003_FFFC;

    rst = 1'b1;
    rdy = 1'b1;
    in_rx_valid = 1'b0;
    in_rx_data = 8'h00;
    bus(1'b0, 32'h0, 8'h00);
    repeat (3) step();
    check("rst_ram_data", out_ram_data, 8'h00);
    check("rst_uart_full", out_uart_full, 1'b0);
    check("rst_tx", out_tx, 1'b1);
    check("rst_overflow", out_overflow, 1'b0);
    check("rst_halt", out_halt, 1'b0);
    rst = 1'b0;

    // RAM write, read-after-write, untouched byte
    bus(1'b1, 32'h11, 8'h00); step();
    bus(1'b1, 32'h10, 8'hAB); step();
    bus(1'b0, 32'h10, 8'h00); step();
    check("ram_raw", out_ram_data, 8'hAB);
    bus(1'b0, 32'h11, 8'h00); step();
    check("ram_read_zero", out_ram_data, 8'h00);

    // Exact waveform for 0x55
    bus(1'b1, 32'h30000, 8'h55); expq.push_back(8'h55); step();
    bus(1'b0, 32'h20, 8'h00);
    for (int c = 1; c <= 42; c++) begin
      check("tx_55", out_tx, exp_tx(c, 8'h55));
      check("tx_55_full", out_uart_full, 1'b0);
      step();
    end

    // Burst of 10 writes into an 8-deep FIFO
    cnt_m = 0;
    ovf_m = 1'b0;
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      bus(1'b1, 32'h30000, b);
      if (cnt_m < 8) begin
        cnt_m++;
        expq.push_back(b);
      end else begin
        ovf_m = 1'b1;
      end
      if (i == 1) cnt_m--;
      step();
      check("burst_full", out_uart_full, cnt_m >= 6);
      check("burst_ovf", out_overflow, ovf_m);
    end
    bus(1'b0, 32'h20, 8'h00);
    repeat (9 * (10 * BD + 1) + 20) step();
    check("burst_drained", expq.size(), 0);
    check("burst_full_clear", out_uart_full, 1'b0);
    check("ovf_sticky", out_overflow, 1'b1);

    // RX holding register
    in_rx_valid = 1'b1; in_rx_data = 8'h3C; step(); in_rx_valid = 1'b0;
    bus(1'b0, 32'h30004, 8'h00); step();
    check("status_rx", out_ram_data, 8'h02);
    bus(1'b0, 32'h30000, 8'h00); step();
    check("rx_pop", out_ram_data, 8'h3C);
    bus(1'b0, 32'h30000, 8'h00); step();
    check("rx_empty", out_ram_data, 8'h00);
    bus(1'b0, 32'h20, 8'h00);
    in_rx_valid = 1'b1; in_rx_data = 8'h22; step(); in_rx_valid = 1'b0;
    bus(1'b0, 32'h30000, 8'h00);
    in_rx_valid = 1'b1; in_rx_data = 8'h11; step(); in_rx_valid = 1'b0;
    check("rx_coincide_old", out_ram_data, 8'h22);
    step();
    check("rx_coincide_new", out_ram_data, 8'h11);
    step();
    check("rx_empty2", out_ram_data, 8'h00);
    bus(1'b0, 32'h20, 8'h00);
    rdy = 1'b0; in_rx_valid = 1'b1; in_rx_data = 8'h77; step();
    rdy = 1'b1; in_rx_valid = 1'b0;
    bus(1'b0, 32'h30004, 8'h00); step();
    check("rx_lost_rdy0", out_ram_data, 8'h00);

    // rdy freeze mid-frame, with a RAM write presented while frozen
    bus(1'b1, 32'h40, 8'h5A); step();
    b = 8'($urandom);
    bus(1'b1, 32'h30000, b); expq.push_back(b); step();
    bus(1'b0, 32'h20, 8'h00);
    for (int c = 1; c <= 42; c++) begin
      check("tx_freeze", out_tx, exp_tx(c, b));
      if (c == 15) begin
        rdy = 1'b0;
        bus(1'b1, 32'h40, 8'h99);
        repeat (20) begin
          step();
          check("tx_frozen", out_tx, exp_tx(15, b));
        end
        rdy = 1'b1;
        bus(1'b0, 32'h20, 8'h00);
      end
      step();
    end
    bus(1'b0, 32'h40, 8'h00); step();
    check("ram_frozen_write", out_ram_data, 8'h5A);

    // Reset during DATA
    bus(1'b1, 32'h30004, 8'h00); step();
    check("halt_set", out_halt, 1'b1);
    b1 = 8'($urandom);
    bus(1'b1, 32'h30000, b1); expq.push_back(b1); step();
    b = 8'($urandom);
    bus(1'b1, 32'h30000, b); expq.push_back(b); step();
    bus(1'b0, 32'h20, 8'h00);
    repeat (10) step();
    check("pre_rst_tx", out_tx, exp_tx(12, b1));
    rst = 1'b1; step(); rst = 1'b0;
    expq.delete();
    fr0 = frames;
    check("rst_mid_tx", out_tx, 1'b1);
    check("rst_mid_full", out_uart_full, 1'b0);
    check("rst_mid_halt", out_halt, 1'b0);
    check("rst_mid_ovf", out_overflow, 1'b0);
    bus(1'b0, 32'h30004, 8'h00);
    repeat (60) step();
    check("no_frame_after_rst", frames - fr0, 0);
    check("tx_idle_after_rst", out_tx, 1'b1);
    check("status_after_rst", out_ram_data, 8'h00);
    bus(1'b1, 32'h30004, 8'h00); step();
    bus(1'b0, 32'h20, 8'h00);
    check("halt_after_rst", out_halt, 1'b1);
    repeat (10) step();
    check("halt_sticky", out_halt, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 256; i++) begin
      mem_model[i] = 8'($urandom);
      bus(1'b1, ($urandom & 32'hFFFC_0000) | 32'(i), mem_model[i]);
      step();
    end
    rxv = 1'b0;
    rxb = 8'h00;
    idle_cyc = 100;
    for (int it = 0; it < 800; it++) begin
      op  = int'($urandom_range(0, 9));
      idx = int'($urandom_range(0, 255));
      ua  = ($urandom & 32'hFFFC_0000) | 32'(idx);
      wd  = 8'($urandom);
      rxp = ($urandom_range(0, 5) == 0);
      rxd = 8'($urandom);
      do_chk = 1'b0;
      expd = 8'h00;
      if (op == 9 && idle_cyc < 45) op = 3;
      case (op)
        0, 1, 2: begin
          bus(1'b1, ua, wd);
          mem_model[idx] = wd;
        end
        3, 4, 5: begin
          bus(1'b0, ua, 8'h00);
          expd = mem_model[idx];
          do_chk = 1'b1;
        end
        6: begin
          bus(1'b0, 32'h30000, 8'h00);
          expd = rxv ? rxb : 8'h00;
          rxv = 1'b0;
          do_chk = 1'b1;
        end
        7: begin
          bus(1'b0, 32'h30004, 8'h00);
          expd = {6'b0, rxv, 1'b0};
          do_chk = 1'b1;
        end
        8: begin
          rwv = 1'($urandom_range(0, 1));
          bus(rwv, unmapped[$urandom_range(0, 3)], wd);
          do_chk = !rwv;
        end
        default: begin
          bus(1'b1, 32'h30000, wd);
          expq.push_back(wd);
          idle_cyc = 0;
        end
      endcase
      in_rx_valid = rxp;
      in_rx_data = rxd;
      if (rxp) begin
        rxv = 1'b1;
        rxb = rxd;
      end
      step();
      idle_cyc++;
      in_rx_valid = 1'b0;
      if (do_chk) check("rand_rd", out_ram_data, expd);
      if (it % 50 == 0) check("rand_no_ovf", out_overflow, 1'b0);
    end
    bus(1'b0, 32'h20, 8'h00);
    repeat (60) step();
    check("rand_tx_drained", expq.size(), 0);
    check("rand_tx_idle", out_tx, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
